// File: rtl/conduit_panel_ctrl.sv
// Front-panel sequencer for the Qsys custom-module conduit: debounced key press
// latches switches, fires a timed n_action strobe, captures readback, drives 7-seg.
module conduit_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned CAPTURE_DELAY   = 64
) (
  input  logic        clk_50_clk,
  input  logic        reset_reset_n,
  input  logic        key_n,
  input  logic        sw_rdwr,
  input  logic        sw_sel,
  input  logic [15:0] sw_addr,
  input  logic [31:0] display_data,
  output logic        rdwr_cntl,
  output logic        add_data_sel,
  output logic [27:0] rdwr_address,
  output logic        n_action,
  output logic        busy,
  output logic [6:0]  hex0_n,
  output logic [6:0]  hex1_n,
  output logic [6:0]  hex2_n,
  output logic [6:0]  hex3_n,
  output logic [6:0]  hex4_n,
  output logic [6:0]  hex5_n,
  output logic [6:0]  hex6_n,
  output logic [6:0]  hex7_n
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SEQ_MAX = (PULSE_CYCLES > CAPTURE_DELAY) ? PULSE_CYCLES : CAPTURE_DELAY;
  localparam int unsigned SQ_W    = $clog2(SEQ_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  logic [1:0]      r_sync;
  logic            r_deb;
  logic            r_deb_d;
  logic [DB_W-1:0] r_db_cnt;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [SQ_W-1:0] r_seq_cnt;
  logic [SQ_W-1:0] w_cnt_nxt;
  logic            w_strobe_nxt;
  logic            w_press;
  logic            r_n_action;
  logic            r_busy;
  logic            r_rdwr;
  logic            r_sel;
  logic [27:0]     r_addr;
  logic [31:0]     r_cap;

  assign w_press = r_deb_d & ~r_deb;

  // Key synchronizer and debouncer
  always_ff @(posedge clk_50_clk) begin
    if (!reset_reset_n) begin
      r_sync   <= '1;
      r_deb    <= 1'b1;
      r_deb_d  <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_deb_d <= r_deb;
      if (r_sync[1] == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_deb    <= r_sync[1];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // STROBE spends its first cycle with n_action high so the conduit settles first
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_seq_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = '0;
        end
      end
      S_STROBE: begin
        if (r_seq_cnt == SQ_W'(PULSE_CYCLES)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (CAPTURE_DELAY == 1) ? S_CAPTURE : S_WAIT;
        end else begin
          w_cnt_nxt = r_seq_cnt + SQ_W'(1);
        end
      end
      S_WAIT: begin
        if (r_seq_cnt == SQ_W'(CAPTURE_DELAY - 2)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CAPTURE;
        end else begin
          w_cnt_nxt = r_seq_cnt + SQ_W'(1);
        end
      end
      S_CAPTURE: w_state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (r_deb) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_strobe_nxt = (w_state_nxt == S_STROBE) && (w_cnt_nxt != '0);
  end

  always_ff @(posedge clk_50_clk) begin
    if (!reset_reset_n) begin
      r_state    <= S_IDLE;
      r_seq_cnt  <= '0;
      r_n_action <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_seq_cnt  <= w_cnt_nxt;
      r_n_action <= ~w_strobe_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk_50_clk) begin
    if (!reset_reset_n) begin
      r_rdwr <= 1'b0;
      r_sel  <= 1'b0;
      r_addr <= '0;
      r_cap  <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_press) begin
        r_rdwr <= sw_rdwr;
        r_sel  <= sw_sel;
        r_addr <= {10'b0, sw_addr, 2'b00};
      end
      if (r_state == S_CAPTURE) r_cap <= display_data;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign rdwr_cntl    = r_rdwr;
  assign add_data_sel = r_sel;
  assign rdwr_address = r_addr;
  assign n_action     = r_n_action;
  assign busy         = r_busy;
  assign hex0_n       = seg7(r_cap[3:0]);
  assign hex1_n       = seg7(r_cap[7:4]);
  assign hex2_n       = seg7(r_cap[11:8]);
  assign hex3_n       = seg7(r_cap[15:12]);
  assign hex4_n       = seg7(r_cap[19:16]);
  assign hex5_n       = seg7(r_cap[23:20]);
  assign hex6_n       = seg7(r_cap[27:24]);
  assign hex7_n       = seg7(r_cap[31:28]);

endmodule
